// File: rtl/fifo_unpack_pkg.sv
// Shared state encoding and constant helpers for the FIFO read-side unpacker.
package fifo_unpack_pkg;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_BUSY  = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Index width never collapses to zero bits, even when RATIO=1.
  function automatic int idx_w(input int ratio);
    return (clog2(ratio) < 1) ? 1 : clog2(ratio);
  endfunction

endpackage

// File: rtl/fifo_unpack.sv
// Pops wide FIFO words and streams them out as RATIO narrow valid/ready beats.
// Define FIFO_UNPACK_MSB_FIRST_EN to emit the most significant beat first.
module fifo_unpack
  import fifo_unpack_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_ne,
  output logic                 in_re,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_first,
  output logic                 out_last
);

  // IN_WIDTH must be an integer multiple of OUT_WIDTH.
  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDXW  = idx_w(RATIO);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(RATIO - 1);

  logic [RATIO-1:0][OUT_WIDTH-1:0] hold, hold_nxt;
  logic [IDXW-1:0]                 idx, idx_nxt, sel;
  state_t                          state, state_nxt;
  logic                            take;

  assign out_valid = (state == ST_BUSY);
  assign out_first = out_valid && (idx == '0);
  assign out_last  = out_valid && (idx == IDX_LAST);

`ifdef FIFO_UNPACK_MSB_FIRST_EN
  assign sel = IDX_LAST - idx;
`else
  assign sel = idx;
`endif

  assign out_data = hold[sel];
  assign in_re    = take;

  // Popping on the last beat's acceptance keeps the stream bubble-free.
  always_comb begin
    take      = in_ne && ((state == ST_EMPTY) || (out_valid && out_ready && out_last));
    hold_nxt  = hold;
    idx_nxt   = idx;
    state_nxt = state;
    if (take) begin
      hold_nxt  = in_data;
      idx_nxt   = '0;
      state_nxt = ST_BUSY;
    end else if (state == ST_BUSY && out_ready) begin
      if (out_last) begin
        idx_nxt   = '0;
        state_nxt = ST_EMPTY;
      end else begin
        idx_nxt = idx + IDXW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_EMPTY;
      idx   <= '0;
      hold  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      hold  <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_fifo_unpack.sv
// Directed bench for fifo_unpack: 32->8 unpacker plus a 32->32 (RATIO=1) instance.
module tb_fifo_unpack;

  logic        clk, reset;
  logic [31:0] in_data;
  logic        in_ne, out_ready;
  logic        in_re, out_valid, out_first, out_last;
  logic [7:0]  out_data;
  logic        in_re1, out_valid1, out_first1, out_last1;
  logic [31:0] out_data1;

  int n_chk, n_fail;
  logic [31:0] q[$];

  fifo_unpack #(.IN_WIDTH(32), .OUT_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ne(in_ne), .in_re(in_re),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_first(out_first), .out_last(out_last));

  fifo_unpack #(.IN_WIDTH(32), .OUT_WIDTH(32)) dut1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_ne(in_ne), .in_re(in_re1),
    .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_first(out_first1), .out_last(out_last1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written byte tables, LSB first.
  logic [7:0] t1 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] ta [4] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
  logic [7:0] tb [4] = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
  logic [7:0] tc [4] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};

  function automatic int ord(input int k);
`ifdef FIFO_UNPACK_MSB_FIRST_EN
    return 3 - k;
`else
    return k;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    in_ne   = (q.size() != 0);
    in_data = in_ne ? q[0] : 32'h0;
    #1;
  endtask

  task automatic tick();
    logic re;
    re = in_re;
    @(posedge clk);
    if (re) void'(q.pop_front());
    #1;
  endtask

  task automatic expb(input string tag, input logic v, input logic [7:0] d,
                      input logic f, input logic l, input logic re);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    if (v) chk({tag, ".data"}, 32'(out_data), 32'(d));
    chk({tag, ".first"}, 32'(out_first), 32'(f));
    chk({tag, ".last"},  32'(out_last),  32'(l));
    chk({tag, ".re"},    32'(in_re),     32'(re));
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("underflow", 32'(in_re & ~in_ne), 32'h0);
      chk("underflow1", 32'(in_re1 & ~in_ne), 32'h0);
    end
  end

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b1; in_ne = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 32'(out_valid), 0);
    chk("rst.data",  32'(out_data),  0);
    chk("rst.first", 32'(out_first), 0);
    chk("rst.last",  32'(out_last),  0);
    chk("rst.re",    32'(in_re),     0);
    reset = 1'b0;
    tick();

    // 1: single word, plus RATIO=1 instance
    q.push_back(32'h44332211);
    drive(); expb("t1.c0", 0, 8'h00, 0, 0, 1);
    chk("t1r1.re0", 32'(in_re1), 1); chk("t1r1.v0", 32'(out_valid1), 0);
    tick();
    drive(); expb("t1.b0", 1, t1[ord(0)], 1, 0, 0);
    chk("t1r1.v1", 32'(out_valid1), 1); chk("t1r1.d1", out_data1, 32'h44332211);
    chk("t1r1.f1", 32'(out_first1), 1); chk("t1r1.l1", 32'(out_last1), 1);
    chk("t1r1.re1", 32'(in_re1), 0);
    tick();
    drive(); expb("t1.b1", 1, t1[ord(1)], 0, 0, 0);
    chk("t1r1.v2", 32'(out_valid1), 0);
    tick();
    drive(); expb("t1.b2", 1, t1[ord(2)], 0, 0, 0); tick();
    drive(); expb("t1.b3", 1, t1[ord(3)], 0, 1, 0); tick();
    drive(); expb("t1.idle", 0, 8'h00, 0, 0, 0); tick();

    // 2: back-to-back words, no bubble
    q.push_back(32'hA3A2A1A0); q.push_back(32'hB3B2B1B0);
    drive(); expb("t2.c0", 0, 8'h00, 0, 0, 1); tick();
    for (int k = 0; k < 4; k++) begin
      drive(); expb($sformatf("t2.a%0d", k), 1, ta[ord(k)], k == 0, k == 3, k == 3); tick();
    end
    for (int k = 0; k < 4; k++) begin
      drive(); expb($sformatf("t2.b%0d", k), 1, tb[ord(k)], k == 0, k == 3, 0); tick();
    end
    drive(); expb("t2.idle", 0, 8'h00, 0, 0, 0); tick();

    // 3: backpressure on the second beat
    q.push_back(32'h44332211);
    drive(); expb("t3.c0", 0, 8'h00, 0, 0, 1); tick();
    drive(); expb("t3.b0", 1, t1[ord(0)], 1, 0, 0); tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(); expb($sformatf("t3.stall%0d", k), 1, t1[ord(1)], 0, 0, 0); tick();
    end
    out_ready = 1'b1;
    drive(); expb("t3.b1", 1, t1[ord(1)], 0, 0, 0); tick();
    drive(); expb("t3.b2", 1, t1[ord(2)], 0, 0, 0); tick();
    drive(); expb("t3.b3", 1, t1[ord(3)], 0, 1, 0); tick();

    // 4: FIFO stays empty
    for (int k = 0; k < 5; k++) begin
      drive(); expb($sformatf("t4.c%0d", k), 0, 8'h00, 0, 0, 0); tick();
    end

    // 5: reset mid-word, then a fresh word
    q.push_back(32'h44332211);
    drive(); expb("t5.c0", 0, 8'h00, 0, 0, 1); tick();
    drive(); expb("t5.b0", 1, t1[ord(0)], 1, 0, 0); tick();
    drive(); expb("t5.b1", 1, t1[ord(1)], 0, 0, 0); tick();
    q.delete();
    in_ne = 1'b0; in_data = '0;
    reset = 1'b1;
    #1;
    chk("t5.rst.valid", 32'(out_valid), 0);
    chk("t5.rst.data",  32'(out_data),  0);
    chk("t5.rst.first", 32'(out_first), 0);
    chk("t5.rst.last",  32'(out_last),  0);
    chk("t5.rst.re",    32'(in_re),     0);
    chk("t5.rst.valid1", 32'(out_valid1), 0);
    tick();
    reset = 1'b0;
    q.push_back(32'h0D0C0B0A);
    drive(); expb("t5.c1", 0, 8'h00, 0, 0, 1); tick();
    for (int k = 0; k < 4; k++) begin
      drive(); expb($sformatf("t5.n%0d", k), 1, tc[ord(k)], k == 0, k == 3, 0); tick();
    end
    drive(); expb("t5.idle", 0, 8'h00, 0, 0, 0); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
